// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU and its decoder.
// Contents: data width, aluctr operation codes, and a bit-reverse helper
// used by the barrel shifter to implement left shifts on the right-shift path.
package alu_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned CTR_W   = 4;
  localparam int unsigned SHAMT_W = 5;

  // aluctr codes; for sll/pass/xor/or/and, bit 3 is ignored by the ALU
  localparam logic [CTR_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [CTR_W-1:0] ALU_SUB   = 4'b1000;
  localparam logic [CTR_W-1:0] ALU_SLL   = 4'b0001;
  localparam logic [CTR_W-1:0] ALU_SLT   = 4'b0010;
  localparam logic [CTR_W-1:0] ALU_SLTU  = 4'b1010;
  localparam logic [CTR_W-1:0] ALU_PASSB = 4'b0011;
  localparam logic [CTR_W-1:0] ALU_XOR   = 4'b0100;
  localparam logic [CTR_W-1:0] ALU_SRL   = 4'b0101;
  localparam logic [CTR_W-1:0] ALU_SRA   = 4'b1101;
  localparam logic [CTR_W-1:0] ALU_OR    = 4'b0110;
  localparam logic [CTR_W-1:0] ALU_AND   = 4'b0111;

  // Reverse bit order of an XLEN word
  function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] d);
    logic [XLEN-1:0] r;
    r = '0;
    for (int i = 0; i < int'(XLEN); i++) begin
      r[i] = d[int'(XLEN) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rv32_if.sv
// Operand/result bus between the operand-select muxes and the ALU.
// master: drives valid_in, da, db, aluctr; receives valid_out, result, zero.
// slave : the ALU side.
interface alu_rv32_if;
  import alu_pkg::*;

  logic             valid_in;
  logic [XLEN-1:0]  da;
  logic [XLEN-1:0]  db;
  logic [CTR_W-1:0] aluctr;
  logic             valid_out;
  logic [XLEN-1:0]  result;
  logic             zero;

  modport master (
    output valid_in, da, db, aluctr,
    input  valid_out, result, zero
  );

  modport slave (
    input  valid_in, da, db, aluctr,
    output valid_out, result, zero
  );

endinterface

// File: rtl/alu_shifter_rv32.sv
// 5-stage combinational barrel shifter for sll/srl/sra.
// Ports:
//   data_i  : value to shift
//   shamt_i : shift amount (0..31)
//   dir_i   : 1 = right, 0 = left
//   arith_i : with dir_i=1, fill with data_i[31] instead of zeros
//   data_o  : shifted value (combinational)
// Left shifts reuse the right-shift stages on a bit-reversed word.
module alu_shifter_rv32
  import alu_pkg::*;
(
  input  logic [XLEN-1:0]    data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               dir_i,
  input  logic               arith_i,
  output logic [XLEN-1:0]    data_o
);

  logic            fill;
  logic [XLEN-1:0] stg [0:SHAMT_W];

  assign fill   = arith_i & dir_i & data_i[XLEN-1];
  assign stg[0] = dir_i ? data_i : bit_rev(data_i);

  // Stage k shifts right by 2**k when shamt_i[k] is set
  for (genvar gi = 0; gi < int'(SHAMT_W); gi++) begin : g_stage
    localparam int unsigned SH = 32'd1 << gi;
    assign stg[gi+1] = shamt_i[gi] ? {{SH{fill}}, stg[gi][XLEN-1:SH]} : stg[gi];
  end

  assign data_o = dir_i ? stg[SHAMT_W] : bit_rev(stg[SHAMT_W]);

endmodule

// File: rtl/alu_rv32.sv
// Registered 32-bit RV32I ALU.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset (result=0, zero=1, valid_out=0)
//   bus   : slave side of alu_rv32_if (valid_in, da, db, aluctr in;
//           valid_out, result, zero out, all registered, 1-cycle latency)
module alu_rv32
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  alu_rv32_if.slave  bus
);

  localparam int unsigned AW = XLEN + 1;

  logic [CTR_W-1:0] ctr;
  logic [XLEN-1:0]  da;
  logic [XLEN-1:0]  db;

  logic             sub_c;
  logic [XLEN-1:0]  b_op;
  logic [AW-1:0]    sum;
  logic             slt_bit;
  logic             sltu_bit;
  logic [XLEN-1:0]  shift_res;

  logic [XLEN-1:0]  result_d;
  logic             zero_d;
  logic [XLEN-1:0]  result_q;
  logic             zero_q;
  logic             valid_q;

  assign ctr = bus.aluctr;
  assign da  = bus.da;
  assign db  = bus.db;

  // Single 33-bit adder; compares always subtract
  assign sub_c = (ctr == ALU_SUB) || (ctr[2:0] == ALU_SLT[2:0]);
  assign b_op  = db ^ {XLEN{sub_c}};
  assign sum   = {1'b0, da} + {1'b0, b_op} + AW'(sub_c);

  // Signed: differing signs decide directly, else the difference sign does
  assign slt_bit  = (da[XLEN-1] != db[XLEN-1]) ? da[XLEN-1] : sum[XLEN-1];
  // No carry out of da + ~db + 1 means a borrow, i.e. da < db unsigned
  assign sltu_bit = ~sum[XLEN];

  alu_shifter_rv32 u_shifter (
    .data_i  (da),
    .shamt_i (db[SHAMT_W-1:0]),
    .dir_i   (ctr[2]),
    .arith_i (ctr[3]),
    .data_o  (shift_res)
  );

  // Result select on the low 3 bits; bit 3 only picks sub/sltu/sra variants
  always_comb begin
    result_d = '0;
    unique case (ctr[2:0])
      ALU_ADD[2:0]:   result_d = sum[XLEN-1:0];
      ALU_SLL[2:0]:   result_d = shift_res;
      ALU_SLT[2:0]:   result_d = XLEN'(ctr[3] ? sltu_bit : slt_bit);
      ALU_PASSB[2:0]: result_d = db;
      ALU_XOR[2:0]:   result_d = da ^ db;
      ALU_SRL[2:0]:   result_d = shift_res;
      ALU_OR[2:0]:    result_d = da | db;
      ALU_AND[2:0]:   result_d = da & db;
      default:        result_d = '0;
    endcase
  end

  assign zero_d = (result_d == '0);

  // Output register; result/zero hold when no operation is presented
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.valid_in;
      if (bus.valid_in) begin
        result_q <= result_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.valid_out = valid_q;

endmodule

// File: tb/tb_alu_rv32.sv
// Directed self-checking bench for alu_rv32.
module tb_alu_rv32;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_rv32_if bus ();

  alu_rv32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] er, input logic ez,
                     input logic ev);
    checks++;
    assert (bus.result === er && bus.zero === ez && bus.valid_out === ev)
    else begin
      errors++;
      $error("FAIL %s: got result=%h zero=%b valid=%b, want result=%h zero=%b valid=%b",
             tag, bus.result, bus.zero, bus.valid_out, er, ez, ev);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    bus.valid_in = v;
    bus.aluctr   = c;
    bus.da       = a;
    bus.db       = b;
  endtask

  // One operation per cycle, checked just after the capturing edge
  task automatic op(input string tag, input logic [3:0] c, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] er);
    drive(1'b1, c, a, b);
    @(posedge clk);
    #1;
    chk(tag, er, (er == 32'h0), 1'b1);
  endtask

  task automatic idle(input string tag, input logic [31:0] er, input logic ez);
    drive(1'b0, 4'($urandom_range(0, 15)), $urandom | 32'h1, $urandom);
    @(posedge clk);
    #1;
    chk(tag, er, ez, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n  = 1'b0;

    // Reset overrides valid_in
    drive(1'b1, ALU_ADD, 32'h0000_1234, 32'h0000_4321);
    @(posedge clk); #1;
    chk("reset_1", 32'h0, 1'b1, 1'b0);
    drive(1'b1, ALU_OR, $urandom | 32'h1, $urandom);
    @(posedge clk); #1;
    chk("reset_2", 32'h0, 1'b1, 1'b0);

    // Release: first result only after the next edge
    drive(1'b1, ALU_ADD, 32'h1f, 32'h2e);
    rst_n = 1'b1;
    #1;
    chk("latency_pre", 32'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("add", 32'h4d, 1'b0, 1'b1);

    op("sub",        ALU_SUB,   32'h1,          32'h2,          32'hffff_ffff);
    op("xor",        ALU_XOR,   32'h00ff_ee00,  32'h00ff_00cc,  32'h0000_eecc);
    op("or",         ALU_OR,    32'h00ff_ee00,  32'h0000_eeff,  32'h00ff_eeff);
    op("and",        ALU_AND,   32'h00ff_ee00,  32'h00f0_00ff,  32'h00f0_0000);
    op("pass",       ALU_PASSB, 32'hffff_ffff,  32'h1,          32'h1);
    op("pass_b3",    4'b1011,   32'hffff_ffff,  32'h0,          32'h0);
    op("xor_b3",     4'b1100,   32'h1234_5678,  32'h1234_5678,  32'h0);
    op("or_b3",      4'b1110,   32'h0000_0f00,  32'h0000_00f0,  32'h0000_0ff0);
    op("and_b3",     4'b1111,   32'hf0f0_f0f0,  32'h0ff0_0ff0,  32'h00f0_00f0);

    op("sll",        ALU_SLL,   32'h0000_cdef,  32'h4,          32'h000c_def0);
    op("sll_b3",     4'b1001,   32'h0000_cdef,  32'h4,          32'h000c_def0);
    op("sll_shamt",  ALU_SLL,   32'h0000_cdef,  32'h24,         32'h000c_def0);
    op("sll_31",     ALU_SLL,   32'h0000_0003,  32'h1f,         32'h8000_0000);
    op("srl",        ALU_SRL,   32'hfe00_0000,  32'h4,          32'h0fe0_0000);
    op("sra",        ALU_SRA,   32'hfe00_0000,  32'h4,          32'hffe0_0000);
    op("sra_0",      ALU_SRA,   32'h8000_0001,  32'h20,         32'h8000_0001);
    op("sra_31",     ALU_SRA,   32'h8000_0000,  32'h1f,         32'hffff_ffff);
    op("srl_31",     ALU_SRL,   32'h8000_0000,  32'h1f,         32'h0000_0001);
    op("sra_pos",    ALU_SRA,   32'h7000_0000,  32'h8,          32'h0070_0000);

    op("slt_neg",    ALU_SLT,   32'hffff_ffff,  32'h1,          32'h1);
    op("sltu_big",   ALU_SLTU,  32'hffff_ffff,  32'h1,          32'h0);
    op("slt_min",    ALU_SLT,   32'h8000_0000,  32'h7fff_ffff,  32'h1);
    op("sltu_min",   ALU_SLTU,  32'h8000_0000,  32'h7fff_ffff,  32'h0);
    op("slt_max",    ALU_SLT,   32'h7fff_ffff,  32'h8000_0000,  32'h0);
    op("slt_eq",     ALU_SLT,   32'h5,          32'h5,          32'h0);
    op("sltu_lt",    ALU_SLTU,  32'h1,          32'h2,          32'h1);
    op("slt_negneg", ALU_SLT,   32'hffff_fffe,  32'hffff_ffff,  32'h1);

    op("sub_zero",   ALU_SUB,   32'h5,          32'h5,          32'h0);
    op("add_wrap",   ALU_ADD,   32'hffff_ffff,  32'h1,          32'h0);
    op("add_nz",     ALU_ADD,   32'h1,          32'h1,          32'h2);

    // Hold: result/zero frozen, valid_out low
    idle("hold_1", 32'h2, 1'b0);
    idle("hold_2", 32'h2, 1'b0);
    idle("hold_3", 32'h2, 1'b0);
    op("after_hold", ALU_ADD,   32'h3,          32'h4,          32'h7);

    // Mid-stream reset discards the sampled operation
    drive(1'b1, ALU_ADD, 32'h10, 32'h20);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_reset", 32'h0, 1'b1, 1'b0);
    drive(1'b1, ALU_SUB, 32'h10, 32'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_reset", 32'hf, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
